// File: rtl/ifill_responder.sv
// Instruction line-fill responder: fetches one 32-byte line as eight sequential word reads.
// Defining IFILL_LINEBUF_EN adds a one-entry line buffer that answers repeat requests without memory reads.
module ifill_responder #(
  parameter int MEM_LAT = 1
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         req_read,
  input  logic [31:0]  req_addr,
  output logic         req_done,
  output logic [255:0] req_data,
  output logic         mem_rd_en,
  output logic [31:0]  mem_rd_addr,
  input  logic [31:0]  mem_rd_data,
  input  logic         inv_all,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_COLLECT,
    S_DONE,
    S_RECOVER
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        base_q, base_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [MEM_LAT-1:0] ret_vld_q;
  logic [2:0]         ret_idx_q [MEM_LAT];
  logic [255:0]       data_q;
  logic               line_hit;
  logic               last_word;
  logic               unused_bits;

  assign unused_bits = ^{req_addr[4:0], inv_all};
  assign last_word   = ret_vld_q[MEM_LAT-1] && (ret_idx_q[MEM_LAT-1] == 3'd7);

`ifdef IFILL_LINEBUF_EN
  logic        lb_vld_q;
  logic [26:0] lb_tag_q;
  logic        fill_q, fill_d;

  assign line_hit = lb_vld_q && (lb_tag_q == req_addr[31:5]) && !inv_all;
  assign fill_d   = (state_q == S_IDLE && req_read) ? !line_hit : fill_q;

  // Only a line that really came from memory may be remembered.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      lb_vld_q <= 1'b0;
      lb_tag_q <= '0;
      fill_q   <= 1'b0;
    end else begin
      fill_q <= fill_d;
      if (inv_all) begin
        lb_vld_q <= 1'b0;
      end else if (state_q == S_DONE && fill_q) begin
        lb_vld_q <= 1'b1;
        lb_tag_q <= base_q[31:5];
      end
    end
  end
`else
  assign line_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    mem_rd_en   = 1'b0;
    mem_rd_addr = 32'h0;
    req_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_read) begin
          base_d  = {req_addr[31:5], 5'b0};
          cnt_d   = 3'd0;
          state_d = line_hit ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = base_q + {27'd0, cnt_q, 2'b00};
        cnt_d       = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (last_word) state_d = S_DONE;
      end
      S_DONE: begin
        req_done = 1'b1;
        state_d  = S_RECOVER;
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Each issued read carries its word index down a MEM_LAT-deep pipe to meet its data.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      ret_vld_q <= '0;
      for (int k = 0; k < MEM_LAT; k++) ret_idx_q[k] <= '0;
    end else begin
      ret_vld_q[0] <= mem_rd_en;
      ret_idx_q[0] <= cnt_q;
      for (int k = 1; k < MEM_LAT; k++) begin
        ret_vld_q[k] <= ret_vld_q[k-1];
        ret_idx_q[k] <= ret_idx_q[k-1];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (ret_vld_q[MEM_LAT-1]) begin
      data_q[{ret_idx_q[MEM_LAT-1], 5'b0} +: 32] <= mem_rd_data;
    end
  end

  assign req_data = data_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ifill_responder.sv
// Bench for ifill_responder: two instances (MEM_LAT 1 and 3) checked every cycle against an
// event-scheduled model of the fill protocol, plus literal spot values.
module tb_ifill_responder;
  localparam int MAXC = 2048;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic         rst_n;
  logic         inv_all;
  logic         req_read    [2];
  logic [31:0]  req_addr    [2];
  logic         req_done    [2];
  logic [255:0] req_data    [2];
  logic         mem_rd_en   [2];
  logic [31:0]  mem_rd_addr [2];
  logic [31:0]  mem_rd_data [2];
  logic         busy        [2];

  ifill_responder #(.MEM_LAT(1)) u_lat1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .req_read(req_read[0]), .req_addr(req_addr[0]),
    .req_done(req_done[0]), .req_data(req_data[0]), .mem_rd_en(mem_rd_en[0]),
    .mem_rd_addr(mem_rd_addr[0]), .mem_rd_data(mem_rd_data[0]), .inv_all(inv_all),
    .busy(busy[0])
  );

  ifill_responder #(.MEM_LAT(3)) u_lat3 (
    .sys_clk(sys_clk), .rst_n(rst_n), .req_read(req_read[1]), .req_addr(req_addr[1]),
    .req_done(req_done[1]), .req_data(req_data[1]), .mem_rd_en(mem_rd_en[1]),
    .mem_rd_addr(mem_rd_addr[1]), .mem_rd_data(mem_rd_data[1]), .inv_all(inv_all),
    .busy(busy[1])
  );

  int cyc;
  int tests;
  int fails;

  // Expected outputs per instance per cycle, filled in when a request is accepted.
  bit           e_en   [2][MAXC];
  logic [31:0]  e_addr [2][MAXC];
  bit           e_done [2][MAXC];
  bit           e_busy [2][MAXC];
  logic [255:0] e_data [2][MAXC];
  int           free_at [2];
  int           zfrom   [2];
  int           zto     [2];
  logic [255:0] last_line [2];
  bit           hv [2][MAXC];
  logic [31:0]  hd [2][MAXC];
`ifdef IFILL_LINEBUF_EN
  bit           lb_v    [2];
  logic [31:0]  lb_tag  [2];
  int           set_at  [2];
  logic [31:0]  set_tag [2];
`endif

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [255:0] linef(input logic [31:0] b);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = memf(b + 32'(4 * i));
    return l;
  endfunction

  task automatic check(input string name, input int k, input logic [255:0] act,
                       input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d cyc%0d: got %0h, expected %0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic compare_step(input int k, input int c);
    check("rd_en", k, 256'(mem_rd_en[k]), 256'(e_en[k][c]));
    check("rd_addr", k, 256'(mem_rd_addr[k]), 256'(e_en[k][c] ? e_addr[k][c] : 32'h0));
    check("done", k, 256'(req_done[k]), 256'(e_done[k][c]));
    check("busy", k, 256'(busy[k]), 256'(e_busy[k][c]));
    if (e_done[k][c]) check("line", k, req_data[k], e_data[k][c]);
    if (c >= zfrom[k] && c <= zto[k]) check("data_zero", k, req_data[k], 256'h0);
  endtask

  task automatic model_step(input int k, input int c);
    logic [31:0] base;
    bit hit;
    int d;
    if (rst_n !== 1'b1) begin
      for (int j = c + 1; j < MAXC; j++) begin
        e_en[k][j] = 1'b0; e_done[k][j] = 1'b0; e_busy[k][j] = 1'b0;
      end
      free_at[k] = c + 1;
      zfrom[k]   = c + 1;
      zto[k]     = MAXC;
`ifdef IFILL_LINEBUF_EN
      lb_v[k]   = 1'b0;
      set_at[k] = -1;
`endif
    end else begin
      if (req_read[k] === 1'b1 && c >= free_at[k] && c + 14 < MAXC) begin
        base = {req_addr[k][31:5], 5'b0};
        hit  = 1'b0;
`ifdef IFILL_LINEBUF_EN
        hit = lb_v[k] && (lb_tag[k] == base) && (inv_all !== 1'b1);
`endif
        if (zto[k] > c + 1) zto[k] = c + 1;
        if (hit) begin
          e_done[k][c+1] = 1'b1;
          e_data[k][c+1] = last_line[k];
          e_busy[k][c+1] = 1'b1;
          e_busy[k][c+2] = 1'b1;
          free_at[k]     = c + 3;
        end else begin
          for (int i = 0; i < 8; i++) begin
            e_en[k][c+1+i]   = 1'b1;
            e_addr[k][c+1+i] = base + 32'(4 * i);
          end
          d = c + 9 + lat(k);
          e_done[k][d] = 1'b1;
          e_data[k][d] = linef(base);
          for (int j = c + 1; j <= d + 1; j++) e_busy[k][j] = 1'b1;
          free_at[k]   = d + 2;
          last_line[k] = linef(base);
`ifdef IFILL_LINEBUF_EN
          set_at[k]  = d;
          set_tag[k] = base;
`endif
        end
      end
`ifdef IFILL_LINEBUF_EN
      if (inv_all === 1'b1) begin
        lb_v[k] = 1'b0;
      end else if (set_at[k] == c) begin
        lb_v[k]   = 1'b1;
        lb_tag[k] = set_tag[k];
      end
`endif
    end
  endtask

  // Backing memory: answers each read exactly MEM_LAT cycles later, junk otherwise.
  task automatic mem_step(input int k, input int c);
    int j;
    hv[k][c] = (mem_rd_en[k] === 1'b1);
    hd[k][c] = memf(mem_rd_addr[k]);
    j = c - lat(k);
    mem_rd_data[k] = (j >= 0 && hv[k][j]) ? hd[k][j] : 32'hDEAD_BEEF;
  endtask

  task automatic tick();
    @(negedge sys_clk);
    if (cyc < MAXC) begin
      for (int k = 0; k < 2; k++) begin
        compare_step(k, cyc);
        model_step(k, cyc);
        mem_step(k, cyc);
      end
    end
    @(posedge sys_clk);
    cyc++;
    #1;
  endtask

  task automatic wait_done(input int k, output int dc);
    dc = -1;
    for (int n = 0; n < 40 && dc < 0; n++) begin
      if (req_done[k] === 1'b1) dc = cyc;
      else tick();
    end
    if (dc < 0) check("done_timeout", k, 256'd0, 256'd1);
  endtask

  task automatic do_fill(input int k, input logic [31:0] a, input logic inv, input int exp_lat,
                         output int t, output int dc);
    req_addr[k] = a;
    req_read[k] = 1'b1;
    inv_all     = inv;
    t = cyc;
    tick();
    inv_all     = 1'b0;
    req_addr[k] = 32'h9999_9999;
    wait_done(k, dc);
    req_read[k] = 1'b0;
    check("fill_latency", k, 256'(dc - t), 256'(exp_lat));
    tick();
    tick();
  endtask

  task automatic run_suite(input int k);
    int t, dc, dc2, full, hl;
    full = 9 + lat(k);
`ifdef IFILL_LINEBUF_EN
    hl = 1;
`else
    hl = full;
`endif
    req_addr[k] = (k == 0) ? 32'h0000_1234 : 32'h0000_0000;
    req_read[k] = 1'b1;
    t = cyc;
    tick();
    req_addr[k] = 32'h9999_9999;
    wait_done(k, dc);
    check("first_latency", k, 256'(dc - t), (k == 0) ? 256'd10 : 256'd12);
    if (k == 0) begin
      check("w0_literal", k, 256'(req_data[0][31:0]), 256'h0177_7600);
      check("pin_issue_first", k, 256'(e_addr[0][t+1]), 256'h1220);
      check("pin_issue_last", k, 256'(e_addr[0][t+8]), 256'h123C);
    end else begin
      check("w7_literal", k, 256'(req_data[1][255:224]), 256'h134B_643C);
    end
    req_addr[k] = 32'h0000_2000;
    tick();
    wait_done(k, dc2);
    req_read[k] = 1'b0;
    check("b2b_gap", k, 256'(dc2 - dc), (k == 0) ? 256'd12 : 256'd14);
    tick();
    tick();

    req_addr[k] = 32'h0000_0300;
    req_read[k] = 1'b1;
    t = cyc;
    tick();
    tick();
    req_read[k] = 1'b0;
    wait_done(k, dc);
    check("drop_latency", k, 256'(dc - t), 256'(full));
    tick();
    tick();

    req_addr[k] = 32'h0000_0500;
    req_read[k] = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    rst_n = 1'b0;
    tick();
    rst_n       = 1'b1;
    req_read[k] = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    do_fill(k, 32'h0000_0040, 1'b0, full, t, dc);

    do_fill(k, 32'hFFFF_FFE4, 1'b0, full, t, dc);
    check("pin_top_addr", k, 256'(e_addr[k][t+8]), 256'hFFFF_FFFC);

    do_fill(k, 32'h0000_0100, 1'b0, full, t, dc);
    do_fill(k, 32'h0000_011C, 1'b0, hl, t, dc);
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    do_fill(k, 32'h0000_0100, 1'b0, full, t, dc);
    do_fill(k, 32'h0000_0100, 1'b0, hl, t, dc);
    do_fill(k, 32'h0000_0100, 1'b1, full, t, dc);
  endtask

  initial begin
    cyc     = 0;
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    inv_all = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_read[k] = 1'b0;
      req_addr[k] = 32'h0;
      free_at[k]  = 0;
      zfrom[k]    = MAXC;
      zto[k]      = -1;
    end
    @(posedge sys_clk);
    cyc = 1;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
    run_suite(0);
    run_suite(1);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifill_responder.md
IFILL_RESPONDER -- requirements
Module: ifill_responder

Interface
REQ-001 Parameter MEM_LAT, default 1, meaning: backing-memory read latency in cycles, legal range 1..4.
REQ-002 sys_clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_read  input  1  line-fill request from I-cache, level, held until req_done.
REQ-005 req_addr  input  32  byte address of the requested instruction; bits [4:0] ignored.
REQ-006 req_done  output  1  one-cycle pulse: line in req_data valid.
REQ-007 req_data  output  256  filled line; word i at bits [32*i+31:32*i].
REQ-008 mem_rd_en  output  1  backing-memory read strobe, one word per cycle.
REQ-009 mem_rd_addr  output  32  word-aligned byte address of the read.
REQ-010 mem_rd_data  input  32  read data, valid exactly MEM_LAT cycles after the corresponding mem_rd_en cycle.
REQ-011 inv_all  input  1  invalidate line buffer (used only with IFILL_LINEBUF_EN).
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 States: IDLE, ISSUE, COLLECT, DONE, RECOVER.
REQ-014 IDLE: req_read=1 sampled at end of cycle T -> latch base={req_addr[31:5],5'b0}, go ISSUE.
REQ-015 ISSUE: cycles T+1..T+8 assert mem_rd_en, mem_rd_addr=base+4*i, i=0..7 in order; no gaps.
REQ-016 Return tracking: MEM_LAT-deep valid/index shift pipeline; word i captured into req_data slot i at end of its data-valid cycle.
REQ-017 COLLECT: entered after the 8th issue; held until word 7 captured (cycle T+8+MEM_LAT).
REQ-018 DONE: req_done=1 for exactly cycle T+9+MEM_LAT (T+10 for MEM_LAT=1); then RECOVER.
REQ-019 RECOVER: one cycle, req_read ignored; then IDLE. Back-to-back requests: next acceptance no earlier than done cycle +2.
REQ-020 req_data holds last completed line until the next fill's capture overwrites; partial updates during a fill are permitted but req_data is defined only in the req_done cycle.
REQ-021 req_addr changes after acceptance are ignored; base stays latched.
REQ-022 req_read dropped mid-fill: fill runs to completion, req_done still pulses.
REQ-023 mem_rd_addr arithmetic 32-bit; line never crosses a 32-byte boundary, so no wrap within a fill; base 32'hFFFFFFE0 reads ...E0..FC.
REQ-024 mem_rd_en=0 and mem_rd_addr=0 outside ISSUE.

Reset
REQ-025 rst_n=0 at any edge: state IDLE, req_done=0, mem_rd_en=0, mem_rd_addr=0, busy=0, req_data=0, return pipeline valid bits cleared.
REQ-026 Reset mid-fill: in-flight memory returns after reset are discarded; no req_done for the aborted fill.
REQ-027 First request accepted in the first cycle with rst_n=1.

Configuration
REQ-028 Macro IFILL_LINEBUF_EN defined: one-entry tag (base) + valid bit for last completed line.
REQ-029 With it: IDLE request whose base equals tag and valid=1 -> no mem_rd_en, go straight to DONE; req_done in cycle T+1 with unchanged req_data; then RECOVER.
REQ-030 With it: valid set at DONE of a memory fill; cleared by reset or inv_all=1; inv_all coincident with a hit request -> treated as miss, full fill.
REQ-031 Without it: no tag/valid storage, every request performs a full fill, inv_all ignored.

Verification
REQ-032 MEM_LAT=1, req_addr=32'h00001234 at T -> mem_rd_en T+1..T+8 addrs 0x1220..0x123C; req_done only at T+10; req_data[31:0]=mem[0x1220].
REQ-033 MEM_LAT=3, req_addr=32'h0 -> req_done only at T+12; all 8 words in correct slots.
REQ-034 req_read held high after req_done -> no mem_rd_en in RECOVER cycle; second fill issues from done+2.
REQ-035 rst_n=0 at T+4 of a fill -> all outputs 0 next cycle; late returns ignored; new request at 0x40 fills correctly, single req_done.
REQ-036 IFILL_LINEBUF_EN: fill 0x100, re-request 0x11C -> req_done at T+1, zero mem_rd_en; inv_all pulse, re-request 0x100 -> full 8-read fill.
REQ-037 req_addr=32'hFFFFFFE4 -> reads 0xFFFFFFE0..0xFFFFFFFC, no overflow into 0x0.
